// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings for the ID->EX operand stage.
// Immediate modes, ALU source-B selects and the default datapath width.
package alu_operand_stage_pkg;

    localparam int DATALENGTH = 32;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'b00,
        IMM_ZERO  = 2'b01,
        IMM_UPPER = 2'b10,
        IMM_SHAMT = 2'b11
    } immMode_e;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Bypass select for one operand.
// Selects that are out of range fall back to the register-file value.
module operand_fwd_mux #(
    parameter  int DATA_W  = 32,
    parameter  int NUM_FWD = 2,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [DATA_W-1:0]         reg_val,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]         val
);

    always_comb begin
        val = reg_val;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (sel == SEL_W'(k)) begin
                val = fwd_data[k*DATA_W-1 -: DATA_W];
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand resolution for EX: bypass, immediate extension, B select,
// registered in a one-deep valid/ready slot between ID and EX.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter  int DATA_W  = DATALENGTH,
    parameter  int IMM_W   = 16,
    parameter  int NUM_FWD = 2,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         rs_data,
    input  logic [DATA_W-1:0]         rt_data,
    input  logic [IMM_W-1:0]          imm,
    input  logic [1:0]                imm_mode,
    input  logic                      alu_src,
    input  logic [SEL_W-1:0]          fwd_sel_a,
    input  logic [SEL_W-1:0]          fwd_sel_b,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         src_a,
    output logic [DATA_W-1:0]         src_b,
    output logic [DATA_W-1:0]         store_data
);

    logic [DATA_W-1:0] fwdA;
    logic [DATA_W-1:0] fwdB;
    logic [DATA_W-1:0] extImm;
    logic [DATA_W-1:0] nextB;
    logic              validQ;
    logic              capture;

    operand_fwd_mux #(
        .DATA_W  (DATA_W),
        .NUM_FWD (NUM_FWD)
    ) muxA (
        .sel      (fwd_sel_a),
        .reg_val  (rs_data),
        .fwd_data (fwd_data),
        .val      (fwdA)
    );

    operand_fwd_mux #(
        .DATA_W  (DATA_W),
        .NUM_FWD (NUM_FWD)
    ) muxB (
        .sel      (fwd_sel_b),
        .reg_val  (rt_data),
        .fwd_data (fwd_data),
        .val      (fwdB)
    );

    always_comb begin
        extImm = '0;
        unique case (immMode_e'(imm_mode))
            IMM_SIGN:  extImm = DATA_W'($signed(imm));
            IMM_ZERO:  extImm = DATA_W'(imm);
            IMM_UPPER: extImm = DATA_W'(imm) << (DATA_W - IMM_W);
            IMM_SHAMT: extImm = DATA_W'(imm[10:6]);
        endcase
    end

    assign nextB    = (alu_src == ALU_SRC_IMM) ? extImm : fwdB;
    assign in_ready = !validQ || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            validQ     <= 1'b0;
            src_a      <= '0;
            src_b      <= '0;
            store_data <= '0;
        end else if (flush) begin
            validQ <= 1'b0;
        end else if (capture) begin
            validQ     <= 1'b1;
            src_a      <= fwdA;
            src_b      <= nextB;
            store_data <= fwdB;
        end else if (out_ready) begin
            validQ <= 1'b0;
        end
    end

    assign out_valid = validQ;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and scoreboard bench for alu_operand_stage.
// Defaults: DATA_W=32, IMM_W=16, NUM_FWD=2.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic [1:0]  imm_mode;
    logic        alu_src;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [63:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] store_data;

    int checkCnt = 0;
    int passCnt  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
    } exp_t;

    exp_t q[$];

    alu_operand_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm        (imm),
        .imm_mode   (imm_mode),
        .alu_src    (alu_src),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .fwd_data   (fwd_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .store_data (store_data)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modelExt(input logic [15:0] i,
                                             input logic [1:0] m);
        case (m)
            2'd0:    return {{16{i[15]}}, i};
            2'd1:    return {16'h0, i};
            2'd2:    return {i, 16'h0};
            default: return {27'h0, i[10:6]};
        endcase
    endfunction

    function automatic logic [31:0] modelFwd(input logic [1:0] s,
                                             input logic [31:0] r,
                                             input logic [63:0] f);
        case (s)
            2'd1:    return f[31:0];
            2'd2:    return f[63:32];
            default: return r;
        endcase
    endfunction

    task automatic checkOut(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] st);
        checkVal({tag, "_a"}, src_a, a);
        checkVal({tag, "_b"}, src_b, b);
        checkVal({tag, "_st"}, store_data, st);
    endtask

    initial begin
        exp_t e;
        int captured;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b1;
        rs_data   = 32'hDEAD_0001;
        rt_data   = 32'hDEAD_0002;
        imm       = 16'h1234;
        imm_mode  = 2'd0;
        alu_src   = 1'b0;
        fwd_sel_a = 2'd0;
        fwd_sel_b = 2'd0;
        fwd_data  = 64'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // reset with a pending offer
        repeat (3) begin
            step();
            checkVal("rst_valid", 32'(out_valid), 32'd0);
            checkOut("rst", 32'h0, 32'h0, 32'h0);
        end

        rst     = 1'b0;
        rs_data = 32'h10;
        rt_data = 32'h20;
        #1;
        checkVal("post_rst_valid", 32'(out_valid), 32'd0);
        checkVal("post_rst_ready", 32'(in_ready), 32'd1);
        step();
        checkVal("basic_valid", 32'(out_valid), 32'd1);
        checkOut("basic", 32'h10, 32'h20, 32'h20);

        // forwarding plus sign-extended immediate
        fwd_data  = {32'hBBBB_0000, 32'hAAAA_0000};
        fwd_sel_a = 2'd1;
        fwd_sel_b = 2'd2;
        alu_src   = 1'b1;
        imm       = 16'h8001;
        imm_mode  = 2'd0;
        step();
        checkOut("fwd_sign", 32'hAAAA_0000, 32'hFFFF_8001, 32'hBBBB_0000);

        fwd_sel_a = 2'd3;
        step();
        checkOut("sel_oor", 32'h10, 32'hFFFF_8001, 32'hBBBB_0000);

        imm_mode  = 2'd1;
        fwd_sel_a = 2'd2;
        fwd_sel_b = 2'd2;
        step();
        checkOut("zero", 32'hBBBB_0000, 32'h0000_8001, 32'hBBBB_0000);

        imm_mode  = 2'd2;
        fwd_sel_b = 2'd3;
        step();
        checkOut("upper", 32'hBBBB_0000, 32'h8001_0000, 32'h20);

        imm_mode = 2'd3;
        imm      = 16'h07C0;
        step();
        checkOut("shamt", 32'hBBBB_0000, 32'h0000_001F, 32'h20);

        // stall with changing offers
        out_ready = 1'b0;
        alu_src   = 1'b0;
        fwd_sel_a = 2'd0;
        fwd_sel_b = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rs_data = 32'h100 + 32'(i);
            rt_data = 32'h200 + 32'(i);
            #1;
            checkVal("stall_ready", 32'(in_ready), 32'd0);
            step();
            checkVal("stall_valid", 32'(out_valid), 32'd1);
            checkOut("stall", 32'hBBBB_0000, 32'h0000_001F, 32'h20);
        end

        rs_data   = 32'h333;
        rt_data   = 32'h444;
        out_ready = 1'b1;
        step();
        checkVal("release_valid", 32'(out_valid), 32'd1);
        checkOut("release", 32'h333, 32'h444, 32'h444);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkVal("drain_valid", 32'(out_valid), 32'd0);
        checkOut("drain_hold", 32'h333, 32'h444, 32'h444);
        out_ready = 1'b0;
        #1;
        checkVal("idle_ready", 32'(in_ready), 32'd1);

        // flush kills held and incoming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rs_data   = 32'h555;
        rt_data   = 32'h666;
        step();
        checkVal("pre_flush_valid", 32'(out_valid), 32'd1);
        rs_data = 32'h777;
        rt_data = 32'h888;
        flush   = 1'b1;
        step();
        checkVal("flush_valid", 32'(out_valid), 32'd0);
        checkOut("flush_hold", 32'h555, 32'h666, 32'h666);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        checkVal("flush_gone", 32'(out_valid), 32'd0);
        checkOut("flush_gone", 32'h555, 32'h666, 32'h666);

        // reset beats flush
        in_valid = 1'b1;
        step();
        checkVal("pre_rf_valid", 32'(out_valid), 32'd1);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        checkVal("rst_flush_valid", 32'(out_valid), 32'd0);
        checkOut("rst_flush", 32'h0, 32'h0, 32'h0);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        // random stream against a scoreboard
        captured = 0;
        cyc      = 0;
        while (cyc < 3000 && (captured < 100 || q.size() != 0)) begin
            in_valid  = (captured < 100) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rs_data   = $urandom;
            rt_data   = $urandom;
            imm       = 16'($urandom);
            imm_mode  = 2'(captured % 4);
            alu_src   = 1'($urandom_range(0, 1));
            fwd_sel_a = 2'($urandom_range(0, 3));
            fwd_sel_b = 2'($urandom_range(0, 3));
            fwd_data  = {$urandom, $urandom};
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checkVal("sb_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    checkOut("sb", e.a, e.b, e.st);
                end
            end
            if (in_valid && in_ready) begin
                e.a  = modelFwd(fwd_sel_a, rs_data, fwd_data);
                e.st = modelFwd(fwd_sel_b, rt_data, fwd_data);
                e.b  = alu_src ? modelExt(imm, imm_mode) : e.st;
                q.push_back(e);
                captured++;
            end
            step();
            cyc++;
        end
        checkVal("sb_captured", 32'(captured), 32'd100);
        checkVal("sb_leftover", 32'(q.size()), 32'd0);
        checkVal("sb_end_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
